// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the LFSR PRNG arbiter.
package lfsr_pkg;

    // Arbiter phase: warm-up steps the LFSR blindly, serve hands out words.
    typedef enum logic [0:0] {
        ST_WARMUP = 1'b0,
        ST_SERVE  = 1'b1
    } arb_state_e;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span << 1;
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/lfsr_step_core.sv
// LFSR state register: shift-left with parity feedback, seed mixing and lockup guard.
module lfsr_step_core #(
    parameter int unsigned         REG_BITS = 16,
    parameter logic [REG_BITS-1:0] INIT     = REG_BITS'(1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                step_en,
    input  logic                load_init,
    input  logic [REG_BITS-1:0] seed_applied,
    output logic [REG_BITS-1:0] state
);

    logic [REG_BITS-1:0] state_q;
    logic [REG_BITS-1:0] state_d;
    logic [REG_BITS-1:0] shifted;
    logic                fb;

    // Next LFSR value: reload wins over a step; an all-zero result is forced to 1.
    always_comb begin
        fb      = (^state_q) ^ (^seed_applied);
        shifted = {state_q[REG_BITS-2:0], fb};
        state_d = state_q;
        if (load_init) begin
            state_d = INIT;
        end else if (step_en) begin
            state_d = (shifted == '0) ? REG_BITS'(1) : shifted;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= INIT;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/lfsr_prng_arbiter.sv
// Round-robin arbiter handing one fresh LFSR word per grant, after a seeded warm-up.
module lfsr_prng_arbiter
    import lfsr_pkg::*;
#(
    parameter int unsigned         NUM_REQ  = 4,
    parameter int unsigned         REG_BITS = 16,
    parameter logic [REG_BITS-1:0] INIT     = REG_BITS'(1),
    parameter int unsigned         WARMUP   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [REG_BITS-1:0] seed_in,
    input  logic                seed_load,
    input  logic [NUM_REQ-1:0]  req,
    output logic [NUM_REQ-1:0]  gnt,
    output logic [REG_BITS-1:0] prng_out,
    output logic                busy
);

    localparam int unsigned      PTR_W    = (clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ);
    localparam int unsigned      CNT_W    = clog2(WARMUP) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WARMUP - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

    arb_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [REG_BITS-1:0] seed_q, seed_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [REG_BITS-1:0] prng_q, prng_d;
    logic                busy_q, busy_d;

    logic                step_en;
    logic                load_init;
    logic [REG_BITS-1:0] seed_applied;
    logic [REG_BITS-1:0] lfsr_state;

    logic                pick_valid;
    logic [PTR_W-1:0]    pick_idx;
    logic [PTR_W-1:0]    cand;
    int unsigned         cand_sum;

    lfsr_step_core #(
        .REG_BITS (REG_BITS),
        .INIT     (INIT)
    ) u_core (
        .clk          (clk),
        .rst          (rst),
        .step_en      (step_en),
        .load_init    (load_init),
        .seed_applied (seed_applied),
        .state        (lfsr_state)
    );

    // First requester at or after the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        cand_sum   = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand_sum = 32'(ptr_q) + k;
            if (cand_sum >= NUM_REQ) begin
                cand_sum = cand_sum - NUM_REQ;
            end
            cand = PTR_W'(cand_sum);
            if (!pick_valid && req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Phase sequencing, grant decision and LFSR step control; reseed overrides all.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        seed_d       = seed_q;
        ptr_d        = ptr_q;
        gnt_d        = '0;
        prng_d       = prng_q;
        step_en      = 1'b0;
        load_init    = 1'b0;
        seed_applied = '0;

        if (seed_load) begin
            seed_d    = seed_in;
            load_init = 1'b1;
            cnt_d     = '0;
            state_d   = ST_WARMUP;
        end else begin
            case (state_q)
                ST_WARMUP: begin
                    step_en      = 1'b1;
                    seed_applied = seed_q;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_SERVE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_SERVE: begin
                    if (pick_valid) begin
                        gnt_d   = NUM_REQ'(1) << pick_idx;
                        prng_d  = lfsr_state;
                        step_en = 1'b1;
                        ptr_d   = (pick_idx == PTR_LAST) ? '0 : pick_idx + PTR_W'(1);
                    end
                end
                default: state_d = ST_WARMUP;
            endcase
        end

        busy_d = (state_d == ST_WARMUP);
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_WARMUP;
            cnt_q   <= '0;
            seed_q  <= '0;
            ptr_q   <= '0;
            gnt_q   <= '0;
            prng_q  <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            seed_q  <= seed_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            prng_q  <= prng_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt      = gnt_q;
    assign prng_out = prng_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_lfsr_prng_arbiter.sv
// Bench for lfsr_prng_arbiter: two configurations checked against a behavioural model.
module tb_lfsr_prng_arbiter;

    localparam int unsigned N0 = 4;
    localparam int unsigned N1 = 3;
    localparam logic [3:0]  INIT0 = 4'd1;
    localparam logic [3:0]  INIT1 = 4'd0;
    localparam int unsigned W0 = 1;
    localparam int unsigned W1 = 2;

    logic       clk;
    logic       rst;
    logic [3:0] req0, seed_in0, gnt0, prng0;
    logic       seed_load0, busy0;
    logic [2:0] req1, gnt1;
    logic [3:0] seed_in1, prng1;
    logic       seed_load1, busy1;

    int n_checks = 0;
    int n_errors = 0;

    // Model state per configuration.
    int         m_n[2]    = '{N0, N1};
    int         m_wu[2]   = '{W0, W1};
    logic [3:0] m_init[2] = '{INIT0, INIT1};
    logic [3:0] m_lfsr[2];
    logic [3:0] m_seed[2];
    logic [3:0] m_gnt[2];
    logic [3:0] m_prng[2];
    int         m_cnt[2];
    int         m_ptr[2];
    bit         m_busy[2];

    logic [3:0] log_g0[$], log_p0[$], log_g1[$], log_p1[$];

    logic [3:0] pa[6] = '{4'h3, 4'h6, 4'hC, 4'h8, 4'h1, 4'h3};
    logic [3:0] gb0[4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] gb1[4] = '{4'b010, 4'b100, 4'b001, 4'b010};
    logic [3:0] gc0[3] = '{4'b0010, 4'b1000, 4'b0010};

    lfsr_prng_arbiter #(.NUM_REQ(N0), .REG_BITS(4), .INIT(INIT0), .WARMUP(W0)) u_dut0 (
        .clk(clk), .rst(rst), .seed_in(seed_in0), .seed_load(seed_load0),
        .req(req0), .gnt(gnt0), .prng_out(prng0), .busy(busy0)
    );

    lfsr_prng_arbiter #(.NUM_REQ(N1), .REG_BITS(4), .INIT(INIT1), .WARMUP(W1)) u_dut1 (
        .clk(clk), .rst(rst), .seed_in(seed_in1), .seed_load(seed_load1),
        .req(req1), .gnt(gnt1), .prng_out(prng1), .busy(busy1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Shift in the parity of state and seed; all-zero results become 1.
    function automatic logic [3:0] spec_step(input logic [3:0] s, input logic [3:0] sd);
        int unsigned ones;
        logic [3:0]  n;
        ones = $countones(s) + $countones(sd);
        n = 4'((s * 2 + (ones % 2)) % 16);
        if (n == 4'd0) n = 4'd1;
        return n;
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            m_lfsr[d] = m_init[d];
            m_seed[d] = 4'd0;
            m_gnt[d]  = 4'd0;
            m_prng[d] = 4'd0;
            m_cnt[d]  = 0;
            m_ptr[d]  = 0;
            m_busy[d] = 1'b1;
        end
    endfunction

    function automatic void model_edge(input int d, input logic [3:0] r, input logic sl,
                                       input logic [3:0] si);
        bit found;
        int idx;
        m_gnt[d] = 4'd0;
        if (sl) begin
            m_seed[d] = si;
            m_lfsr[d] = m_init[d];
            m_cnt[d]  = 0;
            m_busy[d] = 1'b1;
        end else if (m_busy[d]) begin
            m_lfsr[d] = spec_step(m_lfsr[d], m_seed[d]);
            if (m_cnt[d] == m_wu[d] - 1) m_busy[d] = 1'b0;
            else m_cnt[d] = m_cnt[d] + 1;
        end else begin
            found = 1'b0;
            for (int k = 0; k < m_n[d]; k++) begin
                idx = (m_ptr[d] + k) % m_n[d];
                if (!found && r[idx]) begin
                    found     = 1'b1;
                    m_gnt[d]  = 4'(1 << idx);
                    m_prng[d] = m_lfsr[d];
                    m_lfsr[d] = spec_step(m_lfsr[d], 4'd0);
                    m_ptr[d]  = (idx + 1) % m_n[d];
                end
            end
            if (found) begin
                if (d == 0) begin log_g0.push_back(m_gnt[d]); log_p0.push_back(m_prng[d]); end
                else begin log_g1.push_back(m_gnt[d]); log_p1.push_back(m_prng[d]); end
            end
        end
    endfunction

    function automatic void clear_logs();
        log_g0.delete(); log_p0.delete(); log_g1.delete(); log_p1.delete();
    endfunction

    // Model advances on the same edges as the DUTs, including the async reset.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_reset();
        end else begin
            model_edge(0, req0, seed_load0, seed_in0);
            model_edge(1, {1'b0, req1}, seed_load1, seed_in1);
        end
    end

    // Every cycle: DUT outputs against the model, sampled mid-cycle.
    always @(negedge clk) begin
        chk("gnt0", 32'(gnt0), 32'(m_gnt[0]));
        chk("prng0", 32'(prng0), 32'(m_prng[0]));
        chk("busy0", 32'(busy0), 32'(m_busy[0]));
        chk("gnt1", 32'(gnt1), 32'(m_gnt[1]));
        chk("prng1", 32'(prng1), 32'(m_prng[1]));
        chk("busy1", 32'(busy1), 32'(m_busy[1]));
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  b0, b1;
        bit  seen;
        rst = 1'b0; req0 = '0; req1 = '0;
        seed_load0 = 1'b0; seed_load1 = 1'b0; seed_in0 = '0; seed_in1 = '0;
        #1 rst = 1'b1;
        @(negedge clk); @(negedge clk);

        // Single requester after reset: period-5 sequence and warm-up length.
        req0 = 4'b0001; req1 = 3'b001;
        clear_logs();
        rst = 1'b0;
        b0 = int'(m_busy[0]); b1 = int'(m_busy[1]);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i < 4) begin b0 += int'(m_busy[0]); b1 += int'(m_busy[1]); end
        end
        chk("busy_cycles0", 32'(b0), 32'(W0));
        chk("busy_cycles1", 32'(b1), 32'(W1));
        chk("a_len0", 32'(log_p0.size() >= 6), 32'd1);
        for (int i = 0; i < 6; i++) chk($sformatf("a_prng0[%0d]", i), 32'(log_p0[i]), 32'(pa[i]));
        chk("lockup_prng1[0]", 32'(log_p1[0]), 32'h3);
        chk("lockup_prng1[1]", 32'(log_p1[1]), 32'h6);

        // All requesters: rotation, and 3-way wrap on the second config.
        req0 = 4'b1111; req1 = 3'b111;
        clear_logs();
        repeat (4) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("b_gnt0[%0d]", i), 32'(log_g0[i]), 32'(gb0[i]));
            chk($sformatf("b_gnt1[%0d]", i), 32'(log_g1[i]), 32'(gb1[i]));
        end
        for (int i = 1; i < 4; i++) chk("b_prng_changes", 32'(log_p0[i] != log_p0[i-1]), 32'd1);

        // Sparse requests starting from pointer 1.
        req0 = 4'b1010; req1 = 3'b000;
        clear_logs();
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) chk($sformatf("c_gnt0[%0d]", i), 32'(log_g0[i]), 32'(gc0[i]));

        // Reseed in the same cycle as a request; second config also restarts mid warm-up.
        req0 = 4'b0001; req1 = 3'b001;
        @(negedge clk);
        seed_load0 = 1'b1; seed_in0 = 4'hF;
        seed_load1 = 1'b1; seed_in1 = 4'h7;
        @(negedge clk);
        chk("seed_blocks_gnt0", 32'(gnt0), 32'd0);
        chk("seed_busy0", 32'(busy0), 32'd1);
        chk("seed_busy1", 32'(busy1), 32'd1);
        seed_load0 = 1'b0;
        clear_logs();
        @(negedge clk);
        seed_load1 = 1'b0;
        repeat (5) @(negedge clk);
        chk("d_prng0[0]", 32'(log_p0[0]), 32'h3);
        chk("d_prng1[0]", 32'(log_p1[0]), 32'h2);
        chk("d_prng1[1]", 32'(log_p1[1]), 32'h5);

        // Async reset while gnt0 = 0100, then replay of the post-reset sequence.
        req0 = 4'b0100; req1 = 3'b000;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (gnt0 == 4'b0100) begin seen = 1'b1; break; end
        end
        chk("gnt0_reaches_0100", 32'(seen), 32'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_gnt0", 32'(gnt0), 32'd0);
        chk("rst_prng0", 32'(prng0), 32'd0);
        chk("rst_busy0", 32'(busy0), 32'd1);
        chk("rst_busy1", 32'(busy1), 32'd1);
        @(negedge clk); @(negedge clk);
        req0 = 4'b0001;
        clear_logs();
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("e_len0", 32'(log_p0.size() >= 6), 32'd1);
        for (int i = 0; i < 6; i++) chk($sformatf("e_prng0[%0d]", i), 32'(log_p0[i]), 32'(pa[i]));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
